// File: rtl/edge_event_pkg.sv
// edge_event_pkg: shared edge-mode type and index-width helper for the edge event collector
package edge_event_pkg;
   typedef enum logic [1:0] {
      EdgeOff  = 2'b00,
      EdgeRise = 2'b01,
      EdgeFall = 2'b10,
      EdgeBoth = 2'b11
   } edge_mode_e;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/edge_event_channel.sv
// edge_event_channel: one input's synchroniser, edge qualifier, pending/polarity flags and lost-edge counter
module edge_event_channel
   import edge_event_pkg::*;
#(
   parameter int SyncStages = 2,
   parameter int CntWidth   = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                serial_i,
   input  logic [1:0]          mode_i,
   input  logic                warm_done_i,
   input  logic                consume_i,
   output logic                pending_o,
   output logic                fall_o,
   output logic [CntWidth-1:0] drop_cnt_o
);
   logic s, prev_q, rise, fall, qual, take;
   logic pending_q, pending_d, fall_q, fall_d;
   logic [CntWidth-1:0] drop_q, drop_d;
   edge_mode_e mode;
   if (SyncStages == 0) begin : g_nosync
      assign s = serial_i;
   end else begin : g_sync
      logic [SyncStages-1:0] sync_q;
      // shift the raw level through the synchroniser chain; the oldest stage is the sampled value
      always_ff @(posedge clk_i) begin
         if (rst_i) sync_q <= '0;
         else sync_q <= (sync_q << 1) | SyncStages'(serial_i);
      end
      assign s = sync_q[SyncStages-1];
   end
   assign mode = edge_mode_e'(mode_i);
   assign rise = s & ~prev_q;
   assign fall = ~s & prev_q;
   assign qual = warm_done_i & ((rise & (mode == EdgeRise || mode == EdgeBoth)) |
                                (fall & (mode == EdgeFall || mode == EdgeBoth)));
   assign take = qual & (~pending_q | consume_i);
   // an edge is stored only into a free (or just-freed) slot, otherwise the oldest event stays and the loss is counted
   always_comb begin
      pending_d = clr_i ? 1'b0 : (qual | (pending_q & ~consume_i));
      fall_d    = clr_i ? 1'b0 : (take ? fall : fall_q);
      drop_d    = clr_i ? '0 : ((qual & ~take & ~&drop_q) ? drop_q + 1'b1 : drop_q);
   end
   // prev_q keeps tracking the sampled level through clear and warm-up so stale levels never look like edges
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q    <= 1'b0;
         pending_q <= 1'b0;
         fall_q    <= 1'b0;
         drop_q    <= '0;
      end else begin
         prev_q    <= s;
         pending_q <= pending_d;
         fall_q    <= fall_d;
         drop_q    <= drop_d;
      end
   end
   assign pending_o  = pending_q;
   assign fall_o     = fall_q;
   assign drop_cnt_o = drop_q;
endmodule

// File: rtl/edge_event_collector.sv
// edge_event_collector: multi-channel edge capture with round-robin event presentation and drop counting
module edge_event_collector
   import edge_event_pkg::*;
#(
   parameter int NumChannels = 4,
   parameter int SyncStages  = 2,
   parameter int CntWidth    = 4,
   parameter int IdxWidth    = idx_width(NumChannels)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            clr_i,
   input  logic [NumChannels-1:0]          serial_i,
   input  logic [2*NumChannels-1:0]        mode_i,
   output logic                            evt_valid_o,
   input  logic                            evt_ready_i,
   output logic [IdxWidth-1:0]             evt_id_o,
   output logic                            evt_fall_o,
   output logic [NumChannels-1:0]          pending_o,
   output logic [NumChannels*CntWidth-1:0] drop_cnt_o
);
   localparam int WarmWidth = $clog2(SyncStages + 2);
   logic [WarmWidth-1:0] warm_q, warm_d;
   logic [IdxWidth-1:0] rr_q, rr_d, cand;
   logic [NumChannels-1:0] pending, fall;
   logic hs, warm_done;
   assign hs        = evt_valid_o & evt_ready_i;
   assign warm_done = (warm_q == '0);
   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      edge_event_channel #(
         .SyncStages(SyncStages),
         .CntWidth  (CntWidth)
      ) u_ch (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clr_i      (clr_i),
         .serial_i   (serial_i[c]),
         .mode_i     (mode_i[2*c +: 2]),
         .warm_done_i(warm_done),
         .consume_i  (hs & (evt_id_o == IdxWidth'(c))),
         .pending_o  (pending[c]),
         .fall_o     (fall[c]),
         .drop_cnt_o (drop_cnt_o[c*CntWidth +: CntWidth])
      );
   end
   // rotating priority search from rr_q; scanning offsets downwards lets the smallest offset win
   always_comb begin
      evt_id_o = '0;
      cand     = '0;
      for (int i = NumChannels - 1; i >= 0; i--) begin
         cand = IdxWidth'((int'(rr_q) + i) % NumChannels);
         if (pending[cand]) evt_id_o = cand;
      end
   end
   assign evt_valid_o = |pending;
   assign evt_fall_o  = evt_valid_o & fall[evt_id_o];
   assign pending_o   = pending;
   // warm-up countdown and pointer advance past the granted channel, wrapping explicitly for non-power-of-2 counts
   always_comb begin
      warm_d = (warm_q != '0) ? warm_q - 1'b1 : warm_q;
      rr_d   = clr_i ? '0 : (hs ? ((evt_id_o == IdxWidth'(NumChannels - 1)) ? '0 : evt_id_o + 1'b1) : rr_q);
   end
   // warm-up reloads on reset so the synchroniser can fill before any edge is believed
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         warm_q <= WarmWidth'(SyncStages + 1);
         rr_q   <= '0;
      end else begin
         warm_q <= warm_d;
         rr_q   <= rr_d;
      end
   end
endmodule

// File: tb/tb_edge_event_collector.sv
// tb_edge_event_collector: vector table plus hand sequences, with a scoreboard of expected presented events
module tb_edge_event_collector;
   logic        clk_i = 1'b0;
   logic        rst_i, clr_i, evt_ready_i, evt_valid_o, evt_fall_o;
   logic [3:0]  serial_i, pending_o;
   logic [7:0]  mode_i;
   logic [1:0]  evt_id_o;
   logic [15:0] drop_cnt_o;
   int total = 0;
   int passed = 0;
   typedef struct {
      logic       clr;
      logic [3:0] serial;
      logic [7:0] mode;
      logic       ready;
      logic       push;
      logic [1:0] pid;
      logic       pfall;
      logic       valid;
      logic [1:0] id;
      logic       fall;
      logic [3:0] pend;
   } vec_t;
   vec_t tbl [17];
   logic [2:0] sb [$];
   logic [2:0] sb_e;
   always #5 clk_i = ~clk_i;
   edge_event_collector #(.NumChannels(4), .SyncStages(2), .CntWidth(4)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_i),
      .serial_i   (serial_i),
      .mode_i     (mode_i),
      .evt_valid_o(evt_valid_o),
      .evt_ready_i(evt_ready_i),
      .evt_id_o   (evt_id_o),
      .evt_fall_o (evt_fall_o),
      .pending_o  (pending_o),
      .drop_cnt_o (drop_cnt_o)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask
   // every accepted event is compared against the oldest expected entry
   always @(negedge clk_i) begin
      if (evt_valid_o === 1'b1 && evt_ready_i === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_unexpected: got id %0d fall %0d expected no event", evt_id_o, evt_fall_o);
         end else begin
            sb_e = sb.pop_front();
            chk("sb_id", evt_id_o, sb_e[2:1]);
            chk("sb_fall", evt_fall_o, sb_e[0]);
         end
      end
   end
   initial begin
      tbl[0]  = '{0, 4'b0100, 8'h10, 0, 1, 2'd2, 0, 0, 2'd0, 0, 4'b0000};
      tbl[1]  = '{0, 4'b0100, 8'h10, 0, 0, 2'd0, 0, 0, 2'd0, 0, 4'b0000};
      tbl[2]  = '{0, 4'b0100, 8'h10, 0, 0, 2'd0, 0, 1, 2'd2, 0, 4'b0100};
      tbl[3]  = '{0, 4'b0100, 8'h10, 0, 0, 2'd0, 0, 1, 2'd2, 0, 4'b0100};
      tbl[4]  = '{0, 4'b0100, 8'h10, 1, 0, 2'd0, 0, 0, 2'd0, 0, 4'b0000};
      tbl[5]  = '{1, 4'b0100, 8'h10, 0, 0, 2'd0, 0, 0, 2'd0, 0, 4'b0000};
      tbl[6]  = '{0, 4'b1111, 8'h45, 0, 1, 2'd0, 0, 0, 2'd0, 0, 4'b0000};
      tbl[7]  = '{0, 4'b1111, 8'h45, 0, 1, 2'd1, 0, 0, 2'd0, 0, 4'b0000};
      tbl[8]  = '{0, 4'b1111, 8'h45, 0, 1, 2'd3, 0, 1, 2'd0, 0, 4'b1011};
      tbl[9]  = '{0, 4'b1111, 8'h45, 1, 0, 2'd0, 0, 1, 2'd1, 0, 4'b1010};
      tbl[10] = '{0, 4'b1111, 8'h45, 1, 0, 2'd0, 0, 1, 2'd3, 0, 4'b1000};
      tbl[11] = '{0, 4'b1111, 8'h45, 1, 0, 2'd0, 0, 0, 2'd0, 0, 4'b0000};
      tbl[12] = '{0, 4'b0110, 8'hC3, 0, 1, 2'd0, 1, 0, 2'd0, 0, 4'b0000};
      tbl[13] = '{0, 4'b0110, 8'hC3, 0, 1, 2'd3, 1, 0, 2'd0, 0, 4'b0000};
      tbl[14] = '{0, 4'b0110, 8'hC3, 0, 0, 2'd0, 0, 1, 2'd0, 1, 4'b1001};
      tbl[15] = '{0, 4'b0110, 8'hC3, 1, 0, 2'd0, 0, 1, 2'd3, 1, 4'b1000};
      tbl[16] = '{0, 4'b0110, 8'hC3, 1, 0, 2'd0, 0, 0, 2'd0, 0, 4'b0000};
      rst_i = 1'b1; clr_i = 1'b0; evt_ready_i = 1'b0; serial_i = 4'b1111; mode_i = 8'hFF;
      tick(2);
      chk("rst_valid", evt_valid_o, 0);
      chk("rst_id", evt_id_o, 0);
      chk("rst_fall", evt_fall_o, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_drop", drop_cnt_o, 0);
      rst_i = 1'b0;
      tick(10);
      chk("warm_valid", evt_valid_o, 0);
      chk("warm_pending", pending_o, 0);
      chk("warm_drop", drop_cnt_o, 0);
      mode_i = 8'h00; serial_i = 4'b0000;
      tick(4);
      for (int r = 0; r < 17; r++) begin
         clr_i = tbl[r].clr; serial_i = tbl[r].serial; mode_i = tbl[r].mode; evt_ready_i = tbl[r].ready;
         if (tbl[r].push) sb.push_back({tbl[r].pid, tbl[r].pfall});
         tick();
         chk($sformatf("row%0d_valid", r), evt_valid_o, tbl[r].valid);
         chk($sformatf("row%0d_id", r), evt_id_o, tbl[r].id);
         chk($sformatf("row%0d_fall", r), evt_fall_o, tbl[r].fall);
         chk($sformatf("row%0d_pending", r), pending_o, tbl[r].pend);
      end
      evt_ready_i = 1'b0; mode_i = 8'h00; serial_i = 4'b0000;
      tick(4);
      mode_i = 8'h0C; serial_i[1] = 1'b1; sb.push_back({2'd1, 1'b0});
      tick(3);
      chk("drop_first_pending", pending_o, 4'b0010);
      chk("drop_first_id", evt_id_o, 1);
      serial_i[1] = 1'b0;
      tick(3);
      chk("drop_kept_fall", evt_fall_o, 0);
      chk("drop_one", drop_cnt_o[7:4], 1);
      for (int t = 0; t < 10; t++) begin
         serial_i[1] = ~serial_i[1];
         tick(2);
      end
      tick(2);
      chk("drop_eleven", drop_cnt_o[7:4], 11);
      for (int t = 0; t < 10; t++) begin
         serial_i[1] = ~serial_i[1];
         tick(2);
      end
      tick(2);
      chk("drop_saturated", drop_cnt_o[7:4], 15);
      chk("drop_other_zero", drop_cnt_o[3:0], 0);
      evt_ready_i = 1'b1;
      tick();
      evt_ready_i = 1'b0;
      chk("drop_accepted_pending", pending_o, 0);
      mode_i = 8'h03; serial_i[0] = 1'b1; sb.push_back({2'd0, 1'b0});
      tick(3);
      chk("cons_pending", pending_o, 4'b0001);
      serial_i[0] = 1'b0;
      tick(2);
      evt_ready_i = 1'b1;
      tick();
      evt_ready_i = 1'b0;
      chk("cons_refill_pending", pending_o[0], 1);
      chk("cons_refill_fall", evt_fall_o, 1);
      chk("cons_refill_id", evt_id_o, 0);
      chk("cons_no_drop", drop_cnt_o[3:0], 0);
      sb.push_back({2'd0, 1'b1});
      evt_ready_i = 1'b1;
      tick();
      evt_ready_i = 1'b0;
      chk("cons_done_pending", pending_o, 0);
      mode_i = 8'h4F; serial_i = 4'b1010;
      tick(3);
      chk("clr_setup_pending", pending_o, 4'b1010);
      serial_i = 4'b1000;
      tick(3);
      chk("clr_setup_drop", drop_cnt_o[7:4], 15);
      serial_i = 4'b1001;
      tick(2);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("clr_pending", pending_o, 0);
      chk("clr_drop", drop_cnt_o, 0);
      chk("clr_valid", evt_valid_o, 0);
      tick(3);
      chk("clr_edge_discarded", pending_o, 0);
      mode_i = 8'h10; serial_i = 4'b1101; sb.push_back({2'd2, 1'b0});
      tick(3);
      chk("rst_mid_valid_before", evt_valid_o, 1);
      chk("rst_mid_id_before", evt_id_o, 2);
      evt_ready_i = 1'b1; rst_i = 1'b1;
      tick();
      chk("rst_mid_valid", evt_valid_o, 0);
      chk("rst_mid_id", evt_id_o, 0);
      chk("rst_mid_fall", evt_fall_o, 0);
      chk("rst_mid_pending", pending_o, 0);
      chk("rst_mid_drop", drop_cnt_o, 0);
      rst_i = 1'b0; evt_ready_i = 1'b0;
      tick(6);
      chk("rst_high_level_no_event", evt_valid_o, 0);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/edge_event_collector.md
Name: edge_event_collector

Overview:
- Multi-channel edge capture and event queueing block for common_cells.
- Each of NumChannels level inputs passes through an optional synchroniser and a per-channel edge detector (rising, falling, both, or off).
- Each detected edge is latched as a pending event. Pending events are presented one at a time on a valid/ready interface, chosen by round-robin.
- Edges lost while an event is already pending on that channel are counted per channel.

Parameters:
- NumChannels, 4: number of independent level inputs (>=1).
- SyncStages, 2: input synchroniser flops per channel. 0 = input already synchronous, no chain.
- CntWidth, 4: width of each saturating drop counter (>=1).
- IdxWidth, derived: max(1, $clog2(NumChannels)).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clr_i  in  1  synchronous clear of all pending events and drop counters.
- serial_i  in  NumChannels  level inputs, one bit per channel.
- mode_i  in  NumChannels x 2  per-channel edge_mode_e: 00 off, 01 rise, 10 fall, 11 both.
- evt_valid_o  out  1  at least one event pending.
- evt_ready_i  in  1  consumer accepts the presented event.
- evt_id_o  out  IdxWidth  channel index of the presented event.
- evt_fall_o  out  1  polarity of the presented event: 1 = falling edge.
- pending_o  out  NumChannels  raw pending bits.
- drop_cnt_o  out  NumChannels x CntWidth  per-channel saturating lost-edge counters.

Behaviour:
- Reset (rst_i=1 at clk_i edge):
  - Synchroniser flops, prev_q, pending, polarity, drop counters and the round-robin pointer all go to 0.
  - Warm-up counter loads SyncStages+1.
  - Outputs after reset: evt_valid_o=0, evt_id_o=0, evt_fall_o=0, pending_o=0, drop_cnt_o=0.
  - rst_i overrides clr_i and all other activity.
- Warm-up:
  - Detection is suppressed while the warm-up counter is nonzero. The counter decrements by 1 per cycle.
  - prev_q still tracks the synchronised value during warm-up, so a level that is already high after reset produces no event.
- Sample path:
  - s = serial_i when SyncStages=0, otherwise the last synchroniser stage.
  - prev_q <= s every cycle.
  - rise = s & ~prev_q; fall = ~s & prev_q.
  - A qualifying edge is rise or fall permitted by mode_i, sampled in the same cycle.
- Latency:
  - Input change set up before clk_i edge k gives evt_valid_o=1 after edge k+SyncStages.
  - SyncStages=2: 3 edges after the input change (edges k, k+1, k+2). SyncStages=0: after edge k.
- Pending rules, per channel, per cycle:
  - consume = evt_valid_o & evt_ready_i & (evt_id_o == ch).
  - Qualifying edge and (!pending or consume): pending <= 1, polarity <= fall.
  - Qualifying edge and pending and !consume: pending and polarity unchanged (oldest kept); drop counter +1, saturating at 2^CntWidth-1.
  - No edge and consume: pending <= 0.
- Arbitration:
  - evt_id_o = first pending index >= rr_q, wrapping modulo NumChannels. Combinational from registered state only; no combinational path from evt_ready_i to evt_valid_o, evt_id_o or evt_fall_o.
  - On a handshake, rr_q <= evt_id_o+1, or 0 if evt_id_o = NumChannels-1 (non-power-of-2 safe).
  - rr_q holds without a handshake.
  - evt_valid_o = |pending. evt_id_o and evt_fall_o must be stable while evt_valid_o=1 and evt_ready_i=0.
  - evt_ready_i is ignored while evt_valid_o=0.
  - evt_id_o=0 and evt_fall_o=0 when no event is pending.
- clr_i:
  - Clears pending, polarity and drop counters; rr_q <= 0.
  - Edges detected in the same cycle are discarded.
  - Synchroniser, prev_q and warm-up are unaffected.
- mode_i:
  - Changes take effect in the same cycle.
  - Setting off does not clear an already-pending event.

Decomposition:
- Package edge_event_pkg holds:
  - edge_mode_e (2-bit enum: EdgeOff, EdgeRise, EdgeFall, EdgeBoth);
  - the helper function for IdxWidth.
- One sub-module, edge_event_channel, instantiated NumChannels times in a generate loop. It contains:
  - synchroniser chain, prev_q, edge qualification;
  - pending and polarity flops;
  - saturating drop counter.
  - Inputs: warm-up-done, consume, clr.
- The top level holds the warm-up counter and the round-robin pointer/arbiter.

Test Plan:
- Reset with serial_i=4'b1111, mode=both, SyncStages=2 -> no event ever; evt_valid_o=0, drop_cnt_o all 0.
- Ch2 mode=rise, serial_i[2] 0->1 before edge k, evt_ready_i=0 -> evt_valid_o=1 after edge k+2, evt_id_o=2, evt_fall_o=0. Ready held 1 cycle -> pending_o=0.
- Channels 0,1,3 all pending, evt_ready_i=1 continuously, rr_q=0 -> grant order 0,1,3, then 0 for the next new event on ch0 (pointer wraps from 3 to 0). With NumChannels=3, index 2 wraps to 0.
- Ch1 mode=both: rise, then fall while pending and unconsumed -> evt_fall_o=0 kept, drop_cnt_o[1]=1. 20 more toggles with CntWidth=4 -> counter saturates at 15.
- Ch0 pending and consumed in the same cycle a new qualifying fall arrives -> pending_o[0] stays 1, evt_fall_o=1, drop_cnt_o[0] unchanged.
- clr_i=1 with pending=4'b1010 and drop counts nonzero, plus a simultaneous edge on ch0 -> next cycle pending_o=0, drop_cnt_o=0, evt_valid_o=0; rst_i asserted mid-handshake -> all outputs 0 next cycle.
